// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// full_adder : WIDTH-bit ripple-carry adder, combinational and registered outputs
// Revision   : 1.0
// ============================================================================
module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [WIDTH-1:0] sum_q,
   output logic             cout_q,
   output logic             out_valid
);

   logic [WIDTH:0] carry;

   assign carry[0] = cin;

   // One full-adder cell per bit; carry ripples LSB to MSB.
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         assign sum[i]       = a[i] ^ b[i] ^ carry[i];
         assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   endgenerate

   assign cout = carry[WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q     <= '0;
         cout_q    <= 1'b0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         sum_q     <= sum;
         cout_q    <= cout;
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// Testbench for full_adder: truth tables, boundaries, reset, streaming, random sweep.
module tb_full_adder;

   logic clk;
   logic clk_idle;
   logic rst;

   int n_checks;
   int n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // WIDTH=1 instance with clock held idle (combinational truth table)
   logic c1_a, c1_b, c1_cin, c1_iv;
   logic c1_sum, c1_cout, c1_sum_q, c1_cout_q, c1_ov;
   full_adder #(.WIDTH(1)) u_c1 (
      .clk(clk_idle), .rst(1'b0), .a(c1_a), .b(c1_b), .cin(c1_cin), .in_valid(c1_iv),
      .sum(c1_sum), .cout(c1_cout), .sum_q(c1_sum_q), .cout_q(c1_cout_q), .out_valid(c1_ov));

   // WIDTH=1 clocked instance
   logic w1_a, w1_b, w1_cin, w1_iv;
   logic w1_sum, w1_cout, w1_sum_q, w1_cout_q, w1_ov;
   full_adder #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .a(w1_a), .b(w1_b), .cin(w1_cin), .in_valid(w1_iv),
      .sum(w1_sum), .cout(w1_cout), .sum_q(w1_sum_q), .cout_q(w1_cout_q), .out_valid(w1_ov));

   logic [3:0] w4_a, w4_b, w4_sum, w4_sum_q;
   logic       w4_cin, w4_iv, w4_cout, w4_cout_q, w4_ov;
   full_adder #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst(rst), .a(w4_a), .b(w4_b), .cin(w4_cin), .in_valid(w4_iv),
      .sum(w4_sum), .cout(w4_cout), .sum_q(w4_sum_q), .cout_q(w4_cout_q), .out_valid(w4_ov));

   logic [7:0] w8_a, w8_b, w8_sum, w8_sum_q;
   logic       w8_cin, w8_iv, w8_cout, w8_cout_q, w8_ov;
   full_adder #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .a(w8_a), .b(w8_b), .cin(w8_cin), .in_valid(w8_iv),
      .sum(w8_sum), .cout(w8_cout), .sum_q(w8_sum_q), .cout_q(w8_cout_q), .out_valid(w8_ov));

   logic [15:0] w16_a, w16_b, w16_sum, w16_sum_q;
   logic        w16_cin, w16_iv, w16_cout, w16_cout_q, w16_ov;
   full_adder #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst(rst), .a(w16_a), .b(w16_b), .cin(w16_cin), .in_valid(w16_iv),
      .sum(w16_sum), .cout(w16_cout), .sum_q(w16_sum_q), .cout_q(w16_cout_q), .out_valid(w16_ov));

   typedef struct {
      logic       a;
      logic       b;
      logic       cin;
      logic [1:0] exp;   // {cout,sum}
   } tt_vec_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [8:0] exp;   // {cout,sum}
   } w8_vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   tt_vec_t tt [8];
   w8_vec_t bv [3];
   logic [16:0] model;
   logic        model_ov;
   logic [4:0]  exp5;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clk_idle = 1'b0;

      tt[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
      tt[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
      tt[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
      tt[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
      tt[4] = '{1'b1, 1'b0, 1'b0, 2'b01};
      tt[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
      tt[6] = '{1'b1, 1'b1, 1'b0, 2'b10};
      tt[7] = '{1'b1, 1'b1, 1'b1, 2'b11};

      bv[0] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
      bv[1] = '{8'hFF, 8'h00, 1'b1, 9'h100};
      bv[2] = '{8'h00, 8'h00, 1'b0, 9'h000};

      rst = 1'b1;
      {c1_a, c1_b, c1_cin, c1_iv} = '0;
      {w1_a, w1_b, w1_cin, w1_iv} = '0;
      {w4_a, w4_b, w4_cin, w4_iv} = '0;
      {w8_a, w8_b, w8_cin, w8_iv} = '0;
      {w16_a, w16_b, w16_cin, w16_iv} = '0;

      // WIDTH=1 truth table with idle clock
      for (int i = 0; i < 8; i++) begin
         c1_a = tt[i].a; c1_b = tt[i].b; c1_cin = tt[i].cin;
         #1;
         check($sformatf("tt1[%0d]", i), {c1_cout, c1_sum}, tt[i].exp);
         #9;
      end

      // reset state
      tick(); tick();
      check("rst_w1_regs", {w1_ov, w1_cout_q, w1_sum_q}, 3'b000);
      check("rst_w16_regs", {w16_ov, w16_cout_q, w16_sum_q}, 18'h0);
      rst = 1'b0;

      // WIDTH=8 boundaries (combinational)
      for (int i = 0; i < 3; i++) begin
         w8_a = bv[i].a; w8_b = bv[i].b; w8_cin = bv[i].cin;
         #1;
         check($sformatf("w8_bound[%0d]", i), {w8_cout, w8_sum}, bv[i].exp);
      end

      // registered capture then hold
      tick();
      w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b0; w1_iv = 1'b1;
      tick();
      w1_iv = 1'b0;
      check("cap_vals", {w1_cout_q, w1_sum_q}, 2'b10);
      check("cap_valid", w1_ov, 1'b1);
      w1_a = 1'b0; w1_b = 1'b0;
      tick();
      check("hold_valid", w1_ov, 1'b0);
      check("hold_vals", {w1_cout_q, w1_sum_q}, 2'b10);

      // reset priority over in_valid
      w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b1; w1_iv = 1'b1; rst = 1'b1;
      tick();
      check("rprio_regs", {w1_ov, w1_cout_q, w1_sum_q}, 3'b000);
      check("rprio_comb", {w1_cout, w1_sum}, 2'b11);
      rst = 1'b0; w1_iv = 1'b0;

      // WIDTH=4 streaming, back-to-back
      for (int i = 0; i < 16; i++) begin
         w4_a = 4'(i); w4_b = 4'(15 - i); w4_cin = i[0]; w4_iv = 1'b1;
         tick();
         exp5 = 5'(15 + (i % 2));
         check($sformatf("stream[%0d]", i), {w4_ov, w4_cout_q, w4_sum_q}, {1'b1, exp5});
      end
      w4_iv = 1'b0;
      tick();
      check("stream_end_valid", w4_ov, 1'b0);

      // mid-stream reset discards pending result
      w16_a = 16'h1234; w16_b = 16'h1111; w16_cin = 1'b0; w16_iv = 1'b1;
      tick();
      check("mid_pre", {w16_ov, w16_cout_q, w16_sum_q}, {2'b10, 16'h2345});
      w16_a = 16'hFFFF; rst = 1'b1;
      tick();
      rst = 1'b0; w16_iv = 1'b0;
      check("mid_rst", {w16_ov, w16_cout_q, w16_sum_q}, 18'h0);
      tick();
      check("mid_after_valid", w16_ov, 1'b0);

      // random sweep at WIDTH=16 against arithmetic model
      model = '0;
      model_ov = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         w16_a   = 16'($urandom);
         w16_b   = 16'($urandom);
         w16_cin = 1'($urandom);
         w16_iv  = ($urandom_range(0, 3) != 0);
         rst     = ($urandom_range(0, 99) == 0);
         #1;
         check("rnd_comb", {w16_cout, w16_sum}, 17'(w16_a) + 17'(w16_b) + 17'(w16_cin));
         if (rst) begin
            model = '0; model_ov = 1'b0;
         end else if (w16_iv) begin
            model = 17'(w16_a) + 17'(w16_b) + 17'(w16_cin);
            model_ov = 1'b1;
         end else begin
            model_ov = 1'b0;
         end
         @(posedge clk);
         #1;
         check("rnd_reg", {w16_ov, w16_cout_q, w16_sum_q}, {model_ov, model});
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
